// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase controller.
package traffic_pkg;

   typedef enum logic [2:0] {
      MAIN_GREEN  = 3'd0,
      MAIN_YELLOW = 3'd1,
      ALL_RED_A   = 3'd2,
      PED_WALK    = 3'd3,
      SIDE_GREEN  = 3'd4,
      SIDE_YELLOW = 3'd5,
      ALL_RED_B   = 3'd6
   } phase_e;

   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-driven phase timer; done fires on the tick that completes the phase.
module phase_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             tick,
   input  logic [CNT_W-1:0] dur,   // last timer value of the phase, i.e. duration-1
   input  logic             sat,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             at_end;

   assign at_end = (cnt_q >= dur);
   assign done   = tick && at_end;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick && !(sat && at_end)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road plus pedestrian intersection sequencer with latched demand.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned CNT_W            = 8,
   parameter int unsigned MAIN_GREEN_TICKS = 20,
   parameter int unsigned SIDE_GREEN_TICKS = 10,
   parameter int unsigned YELLOW_TICKS     = 3,
   parameter int unsigned ALLRED_TICKS     = 2,
   parameter int unsigned PED_TICKS        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       side_car,
   input  logic       ped_req,
   output logic [2:0] main_light,
   output logic [2:0] side_light,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] state_o
);

   localparam int unsigned MAX_DUR = max_u(max_u(max_u(MAIN_GREEN_TICKS, SIDE_GREEN_TICKS),
                                                 max_u(YELLOW_TICKS, ALLRED_TICKS)), PED_TICKS);

   if (MAIN_GREEN_TICKS < 1 || SIDE_GREEN_TICKS < 1 || YELLOW_TICKS < 1 ||
       ALLRED_TICKS < 1 || PED_TICKS < 1) begin : g_bad_dur
      $error("traffic_phase_ctrl: every phase duration must be at least one tick");
   end
   if (CNT_W < 1 || ((MAX_DUR - 1) >> CNT_W) != 0) begin : g_bad_width
      $error("traffic_phase_ctrl: CNT_W too narrow for the longest phase");
   end

   localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MAIN_GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] SG_LAST = CNT_W'(SIDE_GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] YL_LAST = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_TICKS - 1);
   localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PED_TICKS - 1);

   phase_e           state_q, state_d;
   logic             car_pend_q, car_pend_d;
   logic             ped_pend_q, ped_pend_d;
   logic             ped_ack_q, ped_ack_d;
   logic [CNT_W-1:0] dur;
   logic             sat;
   logic             clr;
   logic             done;

   phase_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tick (tick),
      .dur  (dur),
      .sat  (sat),
      .done (done)
   );

   // Only main green saturates so it can rest there waiting for demand.
   always_comb begin
      dur = AR_LAST;
      sat = 1'b0;
      unique case (state_q)
         MAIN_GREEN: begin
            dur = MG_LAST;
            sat = 1'b1;
         end
         MAIN_YELLOW, SIDE_YELLOW: dur = YL_LAST;
         PED_WALK:                 dur = PW_LAST;
         SIDE_GREEN:               dur = SG_LAST;
         default:                  dur = AR_LAST;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         MAIN_GREEN:  if (done && (car_pend_q || ped_pend_q)) state_d = MAIN_YELLOW;
         MAIN_YELLOW: if (done) state_d = ALL_RED_A;
         ALL_RED_A:   if (done) state_d = ped_pend_q ? PED_WALK : SIDE_GREEN;
         PED_WALK:    if (done) state_d = car_pend_q ? SIDE_GREEN : ALL_RED_B;
         SIDE_GREEN:  if (done) state_d = SIDE_YELLOW;
         SIDE_YELLOW: if (done) state_d = ALL_RED_B;
         ALL_RED_B:   if (done) state_d = MAIN_GREEN;
         default:     state_d = ALL_RED_B;
      endcase
   end

   assign clr = (state_d != state_q);

   // Entering a service phase clears its demand, overriding a same-cycle request.
   always_comb begin
      car_pend_d = car_pend_q |
                   (side_car && state_q != SIDE_GREEN && state_q != SIDE_YELLOW);
      ped_pend_d = ped_pend_q | (ped_req && state_q != PED_WALK);
      if (state_d == SIDE_GREEN && state_q != SIDE_GREEN) car_pend_d = 1'b0;
      if (state_d == PED_WALK && state_q != PED_WALK)     ped_pend_d = 1'b0;
      ped_ack_d = (state_d == PED_WALK) && (state_q != PED_WALK);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ALL_RED_B;
         car_pend_q <= 1'b0;
         ped_pend_q <= 1'b0;
         ped_ack_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         car_pend_q <= car_pend_d;
         ped_pend_q <= ped_pend_d;
         ped_ack_q  <= ped_ack_d;
      end
   end

   always_comb begin
      main_light = LT_RED;
      side_light = LT_RED;
      walk       = 1'b0;
      unique case (state_q)
         MAIN_GREEN:  main_light = LT_GRN;
         MAIN_YELLOW: main_light = LT_YEL;
         PED_WALK:    walk       = 1'b1;
         SIDE_GREEN:  side_light = LT_GRN;
         SIDE_YELLOW: side_light = LT_YEL;
         default:     main_light = LT_RED;
      endcase
   end

   assign ped_ack = ped_ack_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed and randomised checks for traffic_phase_ctrl with short phase durations.
module tb_traffic_phase_ctrl;
   import traffic_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       side_car = 1'b0;
   logic       ped_req = 1'b0;
   logic [2:0] main_light, side_light, state_o;
   logic       walk, ped_ack;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int tick_div = 1;

   always #5 clk = ~clk;

   traffic_phase_ctrl #(
      .CNT_W            (8),
      .MAIN_GREEN_TICKS (4),
      .SIDE_GREEN_TICKS (3),
      .YELLOW_TICKS     (2),
      .ALLRED_TICKS     (1),
      .PED_TICKS        (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .side_car   (side_car),
      .ped_req    (ped_req),
      .main_light (main_light),
      .side_light (side_light),
      .walk       (walk),
      .ped_ack    (ped_ack),
      .state_o    (state_o)
   );

   // {main, side, walk} expected for each state
   function automatic logic [6:0] lights_of(input logic [2:0] s);
      case (s)
         3'd0:    return {3'b001, 3'b100, 1'b0};
         3'd1:    return {3'b010, 3'b100, 1'b0};
         3'd3:    return {3'b100, 3'b100, 1'b1};
         3'd4:    return {3'b100, 3'b001, 1'b0};
         3'd5:    return {3'b100, 3'b010, 1'b0};
         default: return {3'b100, 3'b100, 1'b0};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [2:0] exp);
      check(tag, {22'd0, state_o, main_light, side_light, walk}, {22'd0, exp, lights_of(exp)});
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         tick = (tick_div != 0) && (cyc % tick_div == 0);
      end
   endtask

   task automatic wait_change(input string tag, input int max, output int n);
      logic [2:0] s0;
      s0 = state_o;
      n = 0;
      while (state_o === s0 && n < max) begin
         step(1);
         n++;
      end
      total++;
      assert (state_o !== s0) else begin
         bad++;
         $error("FAIL %s: state stuck at %0d after %0d cycles, expected a change", tag, s0, n);
      end
   endtask

   initial begin
      int         n;
      int         inv_errs;
      int         car_cnt, ped_cnt, car_max, ped_max;
      logic       car_wait, ped_wait;
      logic       prev_main_nr, prev_side_nr, main_nr, side_nr;
      logic [2:0] pre;

      // reset
      tick = 1'b1;
      step(2);
      check_state("reset_state", ALL_RED_B);
      check("reset_ack", {31'd0, ped_ack}, 32'd0);
      rst = 1'b1;
      step(1);
      check_state("first_main_green", MAIN_GREEN);
      for (int i = 0; i < 50; i++) begin
         step(1);
         check_state("idle_hold", MAIN_GREEN);
      end

      // side car only
      side_car = 1'b1;
      step(1);
      side_car = 1'b0;
      check_state("car_latch", MAIN_GREEN);
      step(1); check_state("car_my1", MAIN_YELLOW);
      step(1); check_state("car_my2", MAIN_YELLOW);
      step(1); check_state("car_ara", ALL_RED_A);
      step(1); check_state("car_sg1", SIDE_GREEN);
      step(2); check_state("car_sg3", SIDE_GREEN);
      step(1); check_state("car_sy1", SIDE_YELLOW);
      step(1); check_state("car_sy2", SIDE_YELLOW);
      step(1); check_state("car_arb", ALL_RED_B);
      step(1); check_state("car_back", MAIN_GREEN);
      step(6); check_state("car_cleared", MAIN_GREEN);

      // pedestrian and car together
      side_car = 1'b1;
      ped_req  = 1'b1;
      step(1);
      side_car = 1'b0;
      ped_req  = 1'b0;
      check_state("both_latch", MAIN_GREEN);
      step(1); check_state("both_my", MAIN_YELLOW);
      step(2); check_state("both_ara", ALL_RED_A);
      step(1); check_state("both_pw1", PED_WALK);
      check("both_ack1", {31'd0, ped_ack}, 32'd1);
      step(1); check_state("both_pw2", PED_WALK);
      check("both_ack2", {31'd0, ped_ack}, 32'd0);
      step(2); check_state("both_sg", SIDE_GREEN);
      step(3); check_state("both_sy", SIDE_YELLOW);
      step(2); check_state("both_arb", ALL_RED_B);
      step(1); check_state("both_back", MAIN_GREEN);
      step(6);

      // slow tick, pedestrian only
      tick_div = 4;
      ped_req = 1'b1;
      step(1);
      ped_req = 1'b0;
      wait_change("slow_mg", 40, n);
      check_state("slow_my", MAIN_YELLOW);
      wait_change("slow_my", 40, n);
      check("slow_my_len", n, 8);
      check_state("slow_ara", ALL_RED_A);
      wait_change("slow_ara", 40, n);
      check("slow_ara_len", n, 4);
      check_state("slow_pw", PED_WALK);
      check("slow_ack", {31'd0, ped_ack}, 32'd1);
      ped_req = 1'b1;
      step(1);
      ped_req = 1'b0;
      wait_change("slow_pw", 40, n);
      check("slow_pw_len", n + 1, 12);
      check_state("slow_arb", ALL_RED_B);
      wait_change("slow_arb", 40, n);
      check("slow_arb_len", n, 4);
      check_state("slow_mg_back", MAIN_GREEN);
      step(40);
      check_state("walk_req_ignored", MAIN_GREEN);

      // reset mid side green without tick
      tick_div = 1;
      side_car = 1'b1;
      step(1);
      side_car = 1'b0;
      wait_change("rst_mg", 20, n);
      wait_change("rst_my", 20, n);
      wait_change("rst_ara", 20, n);
      check_state("rst_sg", SIDE_GREEN);
      tick_div = 0;
      tick     = 1'b0;
      ped_req  = 1'b1;
      side_car = 1'b1;
      step(1);
      check_state("rst_sg_hold", SIDE_GREEN);
      rst      = 1'b0;
      ped_req  = 1'b0;
      side_car = 1'b0;
      step(1);
      check_state("rst_mid", ALL_RED_B);
      check("rst_mid_ack", {31'd0, ped_ack}, 32'd0);
      rst      = 1'b1;
      tick_div = 1;
      tick     = 1'b1;
      step(1);
      check_state("rst_release", MAIN_GREEN);
      step(10);
      check_state("rst_pend_cleared", MAIN_GREEN);

      // random traffic
      tick_div = 0;
      inv_errs = 0;
      car_cnt = 0; ped_cnt = 0; car_max = 0; ped_max = 0;
      car_wait = 1'b0; ped_wait = 1'b0;
      prev_main_nr = (main_light != 3'b100);
      prev_side_nr = (side_light != 3'b100);
      for (int i = 0; i < 4000; i++) begin
         pre      = state_o;
         side_car = ($urandom_range(0, 9) == 0);
         ped_req  = ($urandom_range(0, 14) == 0);
         tick     = 1'($urandom_range(0, 1));
         if (side_car && pre != 3'd4 && pre != 3'd5) car_wait = 1'b1;
         if (ped_req && pre != 3'd3) ped_wait = 1'b1;
         @(posedge clk);
         #1;
         main_nr = (main_light != 3'b100);
         side_nr = (side_light != 3'b100);
         if (main_nr && side_nr) inv_errs++;
         if (walk && (main_nr || side_nr)) inv_errs++;
         if ((main_nr && prev_side_nr) || (side_nr && prev_main_nr)) inv_errs++;
         if (ped_ack !== (state_o == 3'd3 && pre != 3'd3)) inv_errs++;
         if ({main_light, side_light, walk} !== lights_of(state_o)) inv_errs++;
         if (state_o == 3'd4 && pre != 3'd4) begin
            car_wait = 1'b0;
            car_cnt  = 0;
         end else if (car_wait) begin
            car_cnt++;
         end
         if (state_o == 3'd3 && pre != 3'd3) begin
            ped_wait = 1'b0;
            ped_cnt  = 0;
         end else if (ped_wait) begin
            ped_cnt++;
         end
         if (car_cnt > car_max) car_max = car_cnt;
         if (ped_cnt > ped_max) ped_max = ped_cnt;
         prev_main_nr = main_nr;
         prev_side_nr = side_nr;
      end
      side_car = 1'b0;
      ped_req  = 1'b0;
      check("rand_invariants", inv_errs, 0);
      check("rand_car_served", {31'd0, car_max < 400}, 32'd1);
      check("rand_ped_served", {31'd0, ped_max < 400}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
